// File: rtl/conv_result_streamer.sv
// Streams a completed convolution result frame out of the result RAM as a
// valid/ready beat stream, tagging end-of-row and end-of-frame beats.
module conv_result_streamer #(
  parameter int OUT_COLS     = 63,
  parameter int OUT_ROWS     = 35,
  parameter int RESULT_WIDTH = 18,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [RESULT_WIDTH-1:0] rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RESULT_WIDTH-1:0] m_data,
  output logic                    m_eol,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    done_q, done_d;

  logic                    inflight_q;
  logic                    inflight_eol_q;
  logic                    inflight_last_q;

  logic [RESULT_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]              fifo_eol_q;
  logic [1:0]              fifo_last_q;
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              count_q;

  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    issue_eol;
  logic                    issue_last;
  logic                    head_last;
  logic [2:0]              occupancy;

  assign issue_eol  = (col_q == COL_W'(OUT_COLS - 1));
  assign issue_last = issue_eol && (row_q == ROW_W'(OUT_ROWS - 1));

  // A read is only issued if its data is guaranteed a free FIFO slot on return.
  assign push      = inflight_q;
  assign pop       = (count_q != 2'd0) && m_ready;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == FETCH) && (occupancy < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (issue_last) begin
            state_d = DRAIN;
            col_d   = '0;
            row_d   = '0;
          end else if (issue_eol) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      col_q           <= '0;
      row_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_eol_q  <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      col_q           <= col_d;
      row_q           <= row_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_eol_q  <= issue_eol;
      inflight_last_q <= issue_last;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_eol_q[wr_ptr_q]  <= inflight_eol_q;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign head_last = fifo_last_q[rd_ptr_q];
  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_eol     = m_valid & fifo_eol_q[rd_ptr_q];
  assign m_last    = m_valid & head_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
